// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC byte supply path.
package cabac_pkg;

    localparam logic [7:0] EPB_BYTE = 8'h03;

    typedef enum logic [1:0] {
        S_Z0 = 2'd0,
        S_Z1 = 2'd1,
        S_Z2 = 2'd2
    } epb_state_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO; head reads as zero while empty.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: head is masked by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cabac_byte_fetcher.sv
// Feeds cleaned slice bytes to the arithmetic decoder, stripping 00 00 03 emulation prevention.
module cabac_byte_fetcher
    import cabac_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   request_byte,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    output logic                   stall,
    output logic [CNT_W-1:0]       epb_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    epb_state_t state, state_nxt;
    logic       accept, drop, push, pop;
    logic       empty, full;

    assign in_ready   = ~full & ~flush;
    assign accept     = in_valid & in_ready;
    assign drop       = accept && (state == S_Z2) && (in_data == EPB_BYTE);
    assign push       = accept & ~drop;
    assign byte_valid = ~empty;
    assign pop        = request_byte & byte_valid;
    assign stall      = request_byte & ~byte_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state <= S_Z0;
        else if (flush) state <= S_Z0;
        else            state <= state_nxt;
    end

    // Zero-run tracker; a dropped 0x03 returns to S_Z0 so the next run starts fresh.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                S_Z0:    state_nxt = (in_data == 8'h00) ? S_Z1 : S_Z0;
                S_Z1:    state_nxt = (in_data == 8'h00) ? S_Z2 : S_Z0;
                S_Z2:    state_nxt = (in_data == 8'h00) ? S_Z2 : S_Z0;
                default: state_nxt = S_Z0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            epb_count <= '0;
        else if (flush)
            epb_count <= '0;
        else if (drop && (epb_count != '1))
            epb_count <= epb_count + CNT_W'(1);
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .head  (byte_out),
        .empty (empty),
        .full  (full),
        .level (fifo_level)
    );

endmodule
